// File: rtl/pc_pkg.sv
// ----------------------------------------------------------------------------
// pc_pkg
// Shared types and constants for the program-counter / fetch-control slice.
//   pc_state_e : fetch FSM states (boot bubble, running, redirect held)
//   pc_sel_e   : next-PC source select
//   PC_RESET_VEC_DEF / PC_TRAP_VEC_DEF : default reset and trap vectors
// ----------------------------------------------------------------------------
package pc_pkg;

    typedef enum logic [1:0] {
        PC_BOOT,
        PC_RUN,
        PC_HOLD
    } pc_state_e;

    typedef enum logic [2:0] {
        SEL_TRAP,
        SEL_REDIR,
        SEL_PEND,
        SEL_HOLD,
        SEL_SEQ
    } pc_sel_e;

    localparam logic [31:0] PC_RESET_VEC_DEF = 32'h0000_0000;
    localparam logic [31:0] PC_TRAP_VEC_DEF  = 32'h0000_0100;

endpackage

// File: rtl/pc_redirect_buf.sv
// ----------------------------------------------------------------------------
// pc_redirect_buf
// One-deep buffer for a redirect target that arrived while fetch was stalled.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   load           : capture target and mark pending (a newer load overwrites)
//   clear          : drop the pending entry (has priority over load)
//   target         : redirect target to capture
//   pend_pc        : buffered target
//   redirect_pend  : buffer holds a target
// ----------------------------------------------------------------------------
module pc_redirect_buf #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            clear,
    input  logic [XLEN-1:0] target,
    output logic [XLEN-1:0] pend_pc,
    output logic            redirect_pend
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_pc       <= '0;
            redirect_pend <= 1'b0;
        end else if (clear) begin
            redirect_pend <= 1'b0;
        end else if (load) begin
            pend_pc       <= target;
            redirect_pend <= 1'b1;
        end
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// ----------------------------------------------------------------------------
// pc_fetch_ctrl
// Fetch program counter plus the IF/ID PC register of the pipelined core.
// Handles reset boot bubble, stall, branch redirect, trap vectoring and a
// one-deep pending-redirect buffer for redirects that arrive during a stall.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   stall            : hold fetch PC and IF/ID register
//   redirect_valid   : taken branch/jump, target on redirect_pc
//   trap             : exception, vector to TRAP_VEC (overrides stall)
//   pc, fetch_valid  : fetch address and its validity (0 during boot bubble)
//   id_pc, id_pc_plus, id_valid : decode-stage PC, PC+INC and slot valid
//   redirect_pend    : a redirect is buffered behind a stall
//   misalign_fault   : only when PC_ALIGN_CHECK_EN is defined; one-cycle
//                      pulse when an applied target is not word aligned
// Configuration macro: PC_ALIGN_CHECK_EN
// ----------------------------------------------------------------------------
module pc_fetch_ctrl
    import pc_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter int              INC       = 4,
    parameter logic [XLEN-1:0] RESET_VEC = XLEN'(PC_RESET_VEC_DEF),
    parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(PC_TRAP_VEC_DEF)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            trap,
    output logic [XLEN-1:0] pc,
    output logic            fetch_valid,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_pc_plus,
    output logic            id_valid,
    output logic            redirect_pend
`ifdef PC_ALIGN_CHECK_EN
    ,
    output logic            misalign_fault
`endif
);

    pc_state_e       state_q, state_d;
    pc_sel_e         sel;
    logic            buf_load;
    logic            buf_clear;
    logic [XLEN-1:0] pend_pc;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] pc_inc;
    logic [XLEN-1:0] pc_d;
    logic            applied_bad;

    pc_redirect_buf #(.XLEN(XLEN)) u_redirect_buf (
        .clk           (clk),
        .rst_n         (rst_n),
        .load          (buf_load),
        .clear         (buf_clear),
        .target        (redirect_pc),
        .pend_pc       (pend_pc),
        .redirect_pend (redirect_pend)
    );

    // Next-state and next-PC source; BOOT ignores every input for one edge.
    always_comb begin
        state_d  = state_q;
        sel      = SEL_HOLD;
        buf_load = 1'b0;
        unique case (state_q)
            PC_BOOT: state_d = PC_RUN;
            default: begin
                if (trap) begin
                    sel     = SEL_TRAP;
                    state_d = PC_RUN;
                end else if (redirect_valid && !stall) begin
                    // A fresh redirect also supersedes anything buffered.
                    sel     = SEL_REDIR;
                    state_d = PC_RUN;
                end else if (redirect_valid) begin
                    sel      = SEL_HOLD;
                    buf_load = 1'b1;
                    state_d  = PC_HOLD;
                end else if (state_q == PC_HOLD && !stall) begin
                    sel     = SEL_PEND;
                    state_d = PC_RUN;
                end else if (stall) begin
                    sel = SEL_HOLD;
                end else begin
                    sel = SEL_SEQ;
                end
            end
        endcase
    end

    assign buf_clear = (sel == SEL_TRAP) || (sel == SEL_REDIR) || (sel == SEL_PEND);
    assign target    = (sel == SEL_PEND) ? pend_pc : redirect_pc;
    assign pc_inc    = pc + XLEN'(INC);

`ifdef PC_ALIGN_CHECK_EN
    // Misaligned targets are dropped and vectored to the trap handler.
    assign applied_bad = ((sel == SEL_REDIR) || (sel == SEL_PEND)) && (target[1:0] != 2'b00);
`else
    assign applied_bad = 1'b0;
`endif

    always_comb begin
        pc_d = pc;
        unique case (sel)
            SEL_TRAP:  pc_d = TRAP_VEC;
            SEL_REDIR,
            SEL_PEND:  pc_d = applied_bad ? TRAP_VEC : target;
            SEL_SEQ:   pc_d = pc_inc;
            default:   pc_d = pc;
        endcase
    end

    assign fetch_valid = (state_q != PC_BOOT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= PC_BOOT;
            pc         <= RESET_VEC;
            id_pc      <= '0;
            id_pc_plus <= '0;
            id_valid   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc      <= pc_d;
            if (sel == SEL_SEQ) begin
                id_pc      <= pc;
                id_pc_plus <= pc_inc;
                id_valid   <= fetch_valid;
            end else if (buf_clear) begin
                // Trap or redirect: the instruction fetched last is wrong-path.
                id_valid <= 1'b0;
            end
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_fault <= 1'b0;
        end else begin
            misalign_fault <= applied_bad;
        end
    end
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pc_fetch_ctrl
// Directed self-checking bench for pc_fetch_ctrl (default parameters).
// Honours PC_ALIGN_CHECK_EN to exercise the alignment-check variant.
// ----------------------------------------------------------------------------
module tb_pc_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        trap;
    logic [31:0] pc;
    logic        fetch_valid;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus;
    logic        id_valid;
    logic        redirect_pend;
`ifdef PC_ALIGN_CHECK_EN
    logic        misalign_fault;
`endif

    int tests_run;
    int tests_failed;

    pc_fetch_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .trap           (trap),
        .pc             (pc),
        .fetch_valid    (fetch_valid),
        .id_pc          (id_pc),
        .id_pc_plus     (id_pc_plus),
        .id_valid       (id_valid),
        .redirect_pend  (redirect_pend)
`ifdef PC_ALIGN_CHECK_EN
        ,
        .misalign_fault (misalign_fault)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        trap           = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        tests_run++; if (pc !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_pc got %h want %h", pc, 32'h0); end
        tests_run++; if (fetch_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_fetch_valid got %b want 0", fetch_valid); end
        tests_run++; if (id_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_id_valid got %b want 0", id_valid); end
        tests_run++; if (id_pc !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_id_pc got %h want 0", id_pc); end
        tests_run++; if (id_pc_plus !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_id_pc_plus got %h want 0", id_pc_plus); end
        tests_run++; if (redirect_pend !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_pend got %b want 0", redirect_pend); end
`ifdef PC_ALIGN_CHECK_EN
        tests_run++; if (misalign_fault !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_misalign got %b want 0", misalign_fault); end
`endif
        rst_n = 1'b1;
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc [4];
        exp_pc[0] = 32'h0; exp_pc[1] = 32'h4; exp_pc[2] = 32'h8; exp_pc[3] = 32'hC;
        // BOOT edge: pc stays at reset vector, fetch becomes valid
        tick();
        tests_run++; if (fetch_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL boot_fetch_valid got %b want 1", fetch_valid); end
        tests_run++; if (id_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL boot_id_valid got %b want 0", id_valid); end
        tests_run++; if (pc !== exp_pc[0]) begin tests_failed++; $display("[TB] FAIL seq_pc0 got %h want %h", pc, exp_pc[0]); end
        for (int i = 1; i < 4; i++) begin
            tick();
            tests_run++; if (pc !== exp_pc[i]) begin tests_failed++; $display("[TB] FAIL seq_pc%0d got %h want %h", i, pc, exp_pc[i]); end
            tests_run++; if (id_pc !== exp_pc[i-1]) begin tests_failed++; $display("[TB] FAIL seq_id_pc%0d got %h want %h", i, id_pc, exp_pc[i-1]); end
            tests_run++; if (id_pc_plus !== exp_pc[i]) begin tests_failed++; $display("[TB] FAIL seq_id_plus%0d got %h want %h", i, id_pc_plus, exp_pc[i]); end
            tests_run++; if (id_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL seq_id_valid%0d got %b want 1", i, id_valid); end
        end
    endtask

    task automatic test_redirect();
        // pc = 0xC -> advance to 0x20
        for (int i = 0; i < 5; i++) tick();
        tests_run++; if (pc !== 32'h20) begin tests_failed++; $display("[TB] FAIL redir_pre_pc got %h want 20", pc); end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80;
        tick();
        idle_inputs();
        tests_run++; if (pc !== 32'h80) begin tests_failed++; $display("[TB] FAIL redir_pc got %h want 80", pc); end
        tests_run++; if (id_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL redir_bubble got %b want 0", id_valid); end
        tests_run++; if (id_pc !== 32'h1C) begin tests_failed++; $display("[TB] FAIL redir_id_pc_hold got %h want 1c", id_pc); end
        tick();
        tests_run++; if (pc !== 32'h84) begin tests_failed++; $display("[TB] FAIL redir_next_pc got %h want 84", pc); end
        tests_run++; if (id_pc !== 32'h80 || id_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL redir_target_decode got %h/%b want 80/1", id_pc, id_valid); end
    endtask

    task automatic test_stall_redirect();
        stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40;
        tick();
        tests_run++; if (pc !== 32'h84) begin tests_failed++; $display("[TB] FAIL stall1_pc got %h want 84", pc); end
        tests_run++; if (redirect_pend !== 1'b1) begin tests_failed++; $display("[TB] FAIL stall1_pend got %b want 1", redirect_pend); end
        tests_run++; if (id_pc !== 32'h80 || id_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL stall1_id_hold got %h/%b want 80/1", id_pc, id_valid); end
        redirect_pc = 32'h60;
        tick();
        redirect_valid = 1'b0;
        tests_run++; if (pc !== 32'h84 || redirect_pend !== 1'b1) begin tests_failed++; $display("[TB] FAIL stall2 got pc %h pend %b want 84/1", pc, redirect_pend); end
        tick();
        tests_run++; if (pc !== 32'h84 || redirect_pend !== 1'b1) begin tests_failed++; $display("[TB] FAIL stall3 got pc %h pend %b want 84/1", pc, redirect_pend); end
        stall = 1'b0;
        tick();
        tests_run++; if (pc !== 32'h60) begin tests_failed++; $display("[TB] FAIL pend_apply_pc got %h want 60", pc); end
        tests_run++; if (redirect_pend !== 1'b0) begin tests_failed++; $display("[TB] FAIL pend_apply_clear got %b want 0", redirect_pend); end
        tests_run++; if (id_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL pend_apply_bubble got %b want 0", id_valid); end
        tick();
        tests_run++; if (pc !== 32'h64 || id_pc !== 32'h60 || id_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL pend_after got pc %h id %h v %b want 64/60/1", pc, id_pc, id_valid); end
    endtask

    task automatic test_trap();
        stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h80;
        tick();
        tests_run++; if (redirect_pend !== 1'b1) begin tests_failed++; $display("[TB] FAIL trap_pre_pend got %b want 1", redirect_pend); end
        trap = 1'b1;
        tick();
        idle_inputs();
        tests_run++; if (pc !== 32'h100) begin tests_failed++; $display("[TB] FAIL trap_pc got %h want 100", pc); end
        tests_run++; if (redirect_pend !== 1'b0) begin tests_failed++; $display("[TB] FAIL trap_pend got %b want 0", redirect_pend); end
        tests_run++; if (id_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL trap_id_valid got %b want 0", id_valid); end
        tick();
        tests_run++; if (pc !== 32'h104) begin tests_failed++; $display("[TB] FAIL trap_after_pc got %h want 104", pc); end
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        idle_inputs();
        tests_run++; if (pc !== 32'hFFFF_FFFC) begin tests_failed++; $display("[TB] FAIL wrap_pre_pc got %h want fffffffc", pc); end
        tick();
        tests_run++; if (pc !== 32'h0) begin tests_failed++; $display("[TB] FAIL wrap_pc got %h want 0", pc); end
        tests_run++; if (id_pc !== 32'hFFFF_FFFC) begin tests_failed++; $display("[TB] FAIL wrap_id_pc got %h want fffffffc", id_pc); end
        tests_run++; if (id_pc_plus !== 32'h0) begin tests_failed++; $display("[TB] FAIL wrap_id_plus got %h want 0", id_pc_plus); end
        tests_run++; if (id_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL wrap_id_valid got %b want 1", id_valid); end
    endtask

    task automatic test_reset_in_hold();
        stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h200;
        tick();
        tests_run++; if (redirect_pend !== 1'b1) begin tests_failed++; $display("[TB] FAIL hold_pend got %b want 1", redirect_pend); end
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++; if (pc !== 32'h0 || fetch_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL async_rst pc %h fv %b want 0/0", pc, fetch_valid); end
        tests_run++; if (redirect_pend !== 1'b0 || id_valid !== 1'b0 || id_pc !== 32'h0) begin tests_failed++; $display("[TB] FAIL async_rst pend %b idv %b idpc %h want 0/0/0", redirect_pend, id_valid, id_pc); end
        idle_inputs();
        tick();
        rst_n = 1'b1;
        tests_run++; if (fetch_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reboot_bubble got %b want 0", fetch_valid); end
        tick();
        tests_run++; if (pc !== 32'h0 || fetch_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL reboot_run pc %h fv %b want 0/1", pc, fetch_valid); end
        tick();
        tests_run++; if (pc !== 32'h4 || id_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL reboot_seq pc %h idv %b want 4/1", pc, id_valid); end
    endtask

    task automatic test_align();
        redirect_valid = 1'b1; redirect_pc = 32'h82;
        tick();
        idle_inputs();
`ifdef PC_ALIGN_CHECK_EN
        tests_run++; if (pc !== 32'h100) begin tests_failed++; $display("[TB] FAIL misalign_pc got %h want 100", pc); end
        tests_run++; if (misalign_fault !== 1'b1) begin tests_failed++; $display("[TB] FAIL misalign_pulse got %b want 1", misalign_fault); end
        tick();
        tests_run++; if (misalign_fault !== 1'b0) begin tests_failed++; $display("[TB] FAIL misalign_clear got %b want 0", misalign_fault); end
        tests_run++; if (pc !== 32'h104) begin tests_failed++; $display("[TB] FAIL misalign_after_pc got %h want 104", pc); end
`else
        tests_run++; if (pc !== 32'h82) begin tests_failed++; $display("[TB] FAIL unaligned_pc got %h want 82", pc); end
        tick();
        tests_run++; if (pc !== 32'h86) begin tests_failed++; $display("[TB] FAIL unaligned_next_pc got %h want 86", pc); end
`endif
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_sequential();
        test_redirect();
        test_stall_redirect();
        test_trap();
        test_wrap();
        test_reset_in_hold();
        test_align();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
